// File: rtl/clock_enable_gen_if.sv
// Control and status bundle for clock_enable_gen: count control, runtime
// divisor write port and the per-channel enable/square-wave outputs.
interface clock_enable_gen_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 27
);
    logic              run;
    logic              pause;
    logic              sync;
    logic              div_wr;
    logic [2:0]        div_sel;
    logic [CNT_W-1:0]  div_data;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic              active;

    modport master (
        output run, pause, sync, div_wr, div_sel, div_data,
        input  tick, sq, active
    );

    modport slave (
        input  run, pause, sync, div_wr, div_sel, div_data,
        output tick, sq, active
    );
endinterface

// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable divider: per-channel tick pulse and square wave,
// with shadowed divisors that only take effect at a wrap or a sync.
module clock_enable_gen #(
    parameter int unsigned             NUM_CH = 4,
    parameter int unsigned             CNT_W  = 27,
    parameter logic [NUM_CH*CNT_W-1:0] DIVS   = {27'd100000000, 27'd50000000,
                                                 27'd25000000, 27'd200000}
) (
    input logic                clk,
    input logic                reset,
    clock_enable_gen_if.slave  bus
);
    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [CNT_W-1:0]  act [NUM_CH];
    logic [CNT_W-1:0]  shd [NUM_CH];
    logic [CNT_W-1:0]  eff [NUM_CH];
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] sq_q;
    logic              active_q;
    logic              en;
    logic              wr_ok;

    assign en    = bus.run & ~bus.pause & ~bus.sync;
    assign wr_ok = bus.div_wr && (32'(bus.div_sel) < NUM_CH);

    // Divisors of 0 and 1 both mean "tick on every enabled cycle".
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            eff[i]  = (act[i] > CNT_W'(1)) ? act[i] : CNT_W'(1);
            wrap[i] = (cnt[i] == eff[i] - CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            tick_q   <= '0;
            sq_q     <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
                act[i] <= DIVS[i*CNT_W +: CNT_W];
                shd[i] <= DIVS[i*CNT_W +: CNT_W];
            end
        end else begin
            active_q <= bus.run & ~bus.pause;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (wr_ok && bus.div_sel == 3'(i))
                    shd[i] <= bus.div_data;
                // A write on the sync edge bypasses the shadow so it lands immediately.
                if (bus.sync) begin
                    cnt[i]    <= '0;
                    tick_q[i] <= 1'b0;
                    sq_q[i]   <= 1'b0;
                    act[i]    <= (wr_ok && bus.div_sel == 3'(i)) ? bus.div_data : shd[i];
                end else if (en) begin
                    if (wrap[i]) begin
                        cnt[i]    <= '0;
                        tick_q[i] <= 1'b1;
                        sq_q[i]   <= ~sq_q[i];
                        act[i]    <= shd[i];
                    end else begin
                        cnt[i]    <= cnt[i] + CNT_W'(1);
                        tick_q[i] <= 1'b0;
                    end
                end else begin
                    tick_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.tick   = tick_q;
    assign bus.sq     = sq_q;
    assign bus.active = active_q;
endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed bench for clock_enable_gen with four small divisors {4,3,2,1}.
module tb_clock_enable_gen;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 8;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    clock_enable_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    clock_enable_gen #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .DIVS   ({8'd4, 8'd3, 8'd2, 8'd1})
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_div(input logic [2:0] sel, input logic [CNT_W-1:0] data);
        bus.div_wr   = 1'b1;
        bus.div_sel  = sel;
        bus.div_data = data;
    endtask

    task automatic clear_wr();
        bus.div_wr   = 1'b0;
        bus.div_sel  = '0;
        bus.div_data = '0;
    endtask

    // Tick vectors for the first six enabled edges with divisors {4,3,2,1}
    logic [3:0] base_ticks [6] = '{4'b0001, 4'b0011, 4'b0101, 4'b1011, 4'b0001, 4'b0111};
    logic [3:0] exp_t;
    logic [3:0] exp_s;

    initial begin
        reset = 1'b1;
        bus.run = 1'b0;
        bus.pause = 1'b0;
        bus.sync = 1'b0;
        clear_wr();
        step();
        step();
        check("reset_tick", 32'(bus.tick), 32'h0);
        check("reset_sq", 32'(bus.sq), 32'h0);
        check("reset_active", 32'(bus.active), 32'h0);

        // Free run: channel i ticks every i+1 edges, sq toggles on each tick.
        reset = 1'b0;
        bus.run = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                exp_t[i] = ((n % (i + 1)) == 0);
                exp_s[i] = ((n / (i + 1)) % 2) == 1;
            end
            check($sformatf("run_tick_e%0d", n), 32'(bus.tick), 32'(exp_t));
            check($sformatf("run_sq_e%0d", n), 32'(bus.sq), 32'(exp_s));
        end
        check("run_active", 32'(bus.active), 32'h1);

        // Pause freezes everything; phase resumes where it stopped.
        step();
        check("pre_pause_tick", 32'(bus.tick), 32'h1);
        bus.pause = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            check($sformatf("pause_tick_%0d", n), 32'(bus.tick), 32'h0);
            check($sformatf("pause_sq_%0d", n), 32'(bus.sq), 32'h1);
        end
        check("pause_active", 32'(bus.active), 32'h0);
        bus.pause = 1'b0;
        step();
        check("resume_tick_e1", 32'(bus.tick), 32'h3);
        step();
        check("resume_tick_e2", 32'(bus.tick), 32'h5);

        // Shadow write mid-period on ch3: old spacing until wrap, then 2.
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        check("sync_tick", 32'(bus.tick), 32'h0);
        check("sync_sq", 32'(bus.sq), 32'h0);
        step();
        write_div(3'd3, 8'd2);
        step();
        clear_wr();
        check("shadow_t3_e2", 32'(bus.tick[3]), 32'h0);
        for (int n = 3; n <= 8; n++) begin
            step();
            check($sformatf("shadow_t3_e%0d", n), 32'(bus.tick[3]), (n == 4 || n == 6 || n == 8) ? 32'h1 : 32'h0);
        end

        // Write on the sync edge lands immediately: ch3 back to 4.
        write_div(3'd3, 8'd4);
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        clear_wr();
        for (int n = 1; n <= 4; n++) begin
            step();
            check($sformatf("syncwr_tick_e%0d", n), 32'(bus.tick), 32'(base_ticks[n-1]));
        end
        step();
        // ch1 would wrap on this edge; sync must win.
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        check("sync_wrap_tick", 32'(bus.tick), 32'h0);
        check("sync_wrap_sq", 32'(bus.sq), 32'h0);
        step();
        check("after_sync_t1_a", 32'(bus.tick[1]), 32'h0);
        step();
        check("after_sync_t1_b", 32'(bus.tick[1]), 32'h1);

        // Divisor 0 on ch2, plus an out-of-range select that must be ignored.
        write_div(3'd2, 8'd0);
        step();
        write_div(3'd5, 8'd1);
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        clear_wr();
        step();
        check("div0_tick_e1", 32'(bus.tick), 32'h5);
        step();
        check("div0_tick_e2", 32'(bus.tick), 32'h7);
        step();
        check("div0_tick_e3", 32'(bus.tick), 32'h5);
        step();
        check("div0_tick_e4", 32'(bus.tick), 32'hf);

        // Reset mid-count with a pending shadow write discards it.
        write_div(3'd1, 8'd7);
        step();
        clear_wr();
        step();
        reset = 1'b1;
        step();
        check("midreset_tick", 32'(bus.tick), 32'h0);
        check("midreset_sq", 32'(bus.sq), 32'h0);
        check("midreset_active", 32'(bus.active), 32'h0);
        reset = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            step();
            check($sformatf("postreset_tick_e%0d", n), 32'(bus.tick), 32'(base_ticks[n-1]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
